// File: rtl/interrupt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_pkg
// Purpose  : Shared defaults, ID width derivation and arbiter state encoding
//            for the interrupt pending/arbitration path.
// Revision : 1.0 - initial release
// ============================================================================
package interrupt_pkg;

    localparam int N_INTERRUPTS_DEFAULT = 32;

    // Width of an interrupt ID; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/interrupt_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_priority_encoder
// Purpose  : Combinational lowest-set-bit encoder. Index 0 has the highest
//            priority; o_valid flags that at least one bit was set.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_priority_encoder
    import interrupt_pkg::*;
#(
    parameter int N_INTERRUPTS = N_INTERRUPTS_DEFAULT,
    parameter int ID_W         = id_width(N_INTERRUPTS)
) (
    input  logic [N_INTERRUPTS-1:0] i_vec,
    output logic [ID_W-1:0]         o_idx,
    output logic                    o_valid
);

    // Scan from the top down so the last hit, the lowest set bit, wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = N_INTERRUPTS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = ID_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_pending_arbiter
// Purpose  : Latches per-source request pulses into a pending register and
//            presents the lowest-index enabled pending interrupt to the core,
//            serviced one at a time through a claim/complete handshake.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_pending_arbiter
    import interrupt_pkg::*;
#(
    parameter int N_INTERRUPTS = N_INTERRUPTS_DEFAULT,
    parameter int ID_W         = id_width(N_INTERRUPTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_INTERRUPTS-1:0] i_interrupt_requests,
    input  logic [N_INTERRUPTS-1:0] i_interrupt_enable,
    input  logic                    i_claim,
    input  logic                    i_complete,
    output logic                    o_irq,
    output logic [ID_W-1:0]         o_irq_id,
    output logic                    o_in_service,
    output logic [ID_W-1:0]         o_in_service_id,
    output logic [N_INTERRUPTS-1:0] o_pending
);

    localparam logic [N_INTERRUPTS-1:0] c_ONE = {{(N_INTERRUPTS-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [N_INTERRUPTS-1:0] r_pending;
    logic                    r_irq;
    logic [ID_W-1:0]         r_irq_id;
    logic [ID_W-1:0]         r_in_service_id;

    logic [N_INTERRUPTS-1:0] w_candidate;
    logic [N_INTERRUPTS-1:0] w_clear_mask;
    logic [ID_W-1:0]         w_enc_id;
    logic                    w_enc_valid;
    logic                    w_accept;
    logic                    w_irq_next;
    logic [ID_W-1:0]         w_irq_id_next;

    assign w_candidate = r_pending & i_interrupt_enable;

    interrupt_priority_encoder #(
        .N_INTERRUPTS (N_INTERRUPTS),
        .ID_W         (ID_W)
    ) u_encoder (
        .i_vec   (w_candidate),
        .o_idx   (w_enc_id),
        .o_valid (w_enc_valid)
    );

    // A claim only counts against a registered irq while idle; the bit it
    // clears is the registered irq_id, even if enables changed this cycle.
    assign w_accept     = (r_state == IDLE) && i_claim && r_irq;
    assign w_clear_mask = w_accept ? (c_ONE << r_irq_id) : '0;

    // Next state and next presented interrupt.
    always_comb begin
        w_state_next  = r_state;
        w_irq_next    = 1'b0;
        w_irq_id_next = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = BUSY;
                end else begin
                    w_irq_next    = w_enc_valid;
                    w_irq_id_next = w_enc_id;
                end
            end
            BUSY: begin
                if (i_complete) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pending bits, presented interrupt and captured in-service ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending       <= '0;
            r_irq           <= 1'b0;
            r_irq_id        <= '0;
            r_in_service_id <= '0;
        end else begin
            // A new pulse overrides a claim-clear of the same bit.
            r_pending <= (r_pending & ~w_clear_mask) | i_interrupt_requests;
            r_irq     <= w_irq_next;
            r_irq_id  <= w_irq_id_next;
            if (w_accept) begin
                r_in_service_id <= r_irq_id;
            end
        end
    end

    assign o_irq           = r_irq;
    assign o_irq_id        = r_irq_id;
    assign o_in_service    = (r_state == BUSY);
    assign o_in_service_id = r_in_service_id;
    assign o_pending       = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_pending_arbiter
// Purpose  : Directed stimulus with a behavioural reference model compared
//            every cycle, plus hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_pending_arbiter;

    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  en  = '0;
    logic          claim = 1'b0;
    logic          complete = 1'b0;
    logic          irq;
    logic [IW-1:0] irq_id;
    logic          in_service;
    logic [IW-1:0] in_service_id;
    logic [N-1:0]  pending;

    int errors = 0;
    int checks = 0;

    interrupt_pending_arbiter #(.N_INTERRUPTS(N)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_interrupt_requests (req),
        .i_interrupt_enable   (en),
        .i_claim              (claim),
        .i_complete           (complete),
        .o_irq                (irq),
        .o_irq_id             (irq_id),
        .o_in_service         (in_service),
        .o_in_service_id      (in_service_id),
        .o_pending            (pending)
    );

    always #5 clk = ~clk;

    // Reference model: one flag per source, a busy flag, and the
    // presented / in-service IDs as plain integers.
    bit m_pend [N];
    bit m_busy;
    bit m_irq;
    int m_id;
    int m_isid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_busy = 0; m_irq = 0; m_id = 0; m_isid = 0;
        end else begin
            bit accepted;
            bit nxt [N];
            int found;
            accepted = !m_busy && claim && m_irq;
            foreach (nxt[i]) begin
                if (req[i])                    nxt[i] = 1'b1;
                else if (accepted && m_id == i) nxt[i] = 1'b0;
                else                            nxt[i] = m_pend[i];
            end
            if (m_busy) begin
                m_irq = 0; m_id = 0;
                if (complete) m_busy = 0;
            end else if (accepted) begin
                m_busy = 1; m_isid = m_id; m_irq = 0; m_id = 0;
            end else begin
                found = -1;
                for (int i = 0; i < N; i++)
                    if (found < 0 && m_pend[i] && en[i]) found = i;
                m_irq = (found >= 0);
                m_id  = (found >= 0) ? found : 0;
            end
            m_pend = nxt;
        end
    end

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model.irq",           32'(irq),           32'(m_irq));
            chk("model.irq_id",        32'(irq_id),        32'(m_id));
            chk("model.in_service",    32'(in_service),    32'(m_busy));
            chk("model.in_service_id", 32'(in_service_id), 32'(m_isid));
            chk("model.pending",       32'(pending),       32'(model_pending()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic claim_complete();
        claim = 1'b1;    step(); claim = 1'b0;
        complete = 1'b1; step(); complete = 1'b0;
    endtask

    initial begin
        en = '1;
        step(2);
        rst = 1'b0;
        step();
        chk("reset.irq",           32'(irq),           32'd0);
        chk("reset.irq_id",        32'(irq_id),        32'd0);
        chk("reset.in_service",    32'(in_service),    32'd0);
        chk("reset.in_service_id", 32'(in_service_id), 32'd0);
        chk("reset.pending",       32'(pending),       32'd0);

        // Single request on bit 5, two-cycle latency, then claim.
        req = 32'h20; step(); req = '0;
        chk("t1.pending_set", 32'(pending), 32'h20);
        chk("t1.irq_not_yet", 32'(irq),     32'd0);
        step();
        chk("t1.irq",    32'(irq),    32'd1);
        chk("t1.irq_id", 32'(irq_id), 32'd5);
        claim = 1'b1; step(); claim = 1'b0;
        chk("t1.pending_clr",   32'(pending),       32'd0);
        chk("t1.in_service",    32'(in_service),    32'd1);
        chk("t1.in_service_id", 32'(in_service_id), 32'd5);
        chk("t1.irq_dropped",   32'(irq),           32'd0);
        complete = 1'b1; step(); complete = 1'b0;
        chk("t1.idle", 32'(in_service), 32'd0);

        // Simultaneous 3 and 9: lowest index first.
        req = 32'h208; step(); req = '0; step();
        chk("t2.first_id", 32'(irq_id), 32'd3);
        claim_complete(); step();
        chk("t2.second_irq", 32'(irq),    32'd1);
        chk("t2.second_id",  32'(irq_id), 32'd9);
        claim_complete(); step();
        chk("t2.none_left", 32'(irq), 32'd0);

        // Set wins over claim-clear of the same bit.
        req = 32'h10; step(); req = '0; step();
        chk("t3.id4", 32'(irq_id), 32'd4);
        claim = 1'b1; req = 32'h10; step(); claim = 1'b0; req = '0;
        chk("t3.pending_kept", 32'(pending),    32'h10);
        chk("t3.busy",         32'(in_service), 32'd1);
        complete = 1'b1; step(); complete = 1'b0; step();
        chk("t3.re_irq", 32'(irq),    32'd1);
        chk("t3.re_id",  32'(irq_id), 32'd4);
        claim_complete(); step();

        // Masked source stays pending and is presented once enabled.
        en = ~32'h80; req = 32'h80; step(); req = '0; step(2);
        chk("t4.masked_irq",     32'(irq),     32'd0);
        chk("t4.masked_pending", 32'(pending), 32'h80);
        en = '1; step();
        chk("t4.irq",    32'(irq),    32'd1);
        chk("t4.irq_id", 32'(irq_id), 32'd7);
        claim = 1'b1; step(); claim = 1'b0;

        // Claims while busy are ignored.
        req = 32'h04; claim = 1'b1; step(); req = '0; step(); claim = 1'b0;
        chk("t5.busy_irq",  32'(irq),           32'd0);
        chk("t5.busy_isid", 32'(in_service_id), 32'd7);
        complete = 1'b1; step(); complete = 1'b0; step();
        chk("t5.irq",    32'(irq),    32'd1);
        chk("t5.irq_id", 32'(irq_id), 32'd2);

        // Async reset while busy with pending 0x0F.
        claim = 1'b1; req = 32'h0F; step(); claim = 1'b0; req = '0;
        chk("t6.pending",    32'(pending),    32'h0F);
        chk("t6.in_service", 32'(in_service), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6.rst_irq",        32'(irq),           32'd0);
        chk("t6.rst_irq_id",     32'(irq_id),        32'd0);
        chk("t6.rst_in_service", 32'(in_service),    32'd0);
        chk("t6.rst_isid",       32'(in_service_id), 32'd0);
        chk("t6.rst_pending",    32'(pending),       32'd0);
        step();
        rst = 1'b0;
        complete = 1'b1; step(); complete = 1'b0; step();
        chk("t6.stray_complete", 32'(in_service), 32'd0);
        chk("t6.no_irq",         32'(irq),        32'd0);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
